pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the MIPS core.
- Holds the fetch PC and selects the next PC from these sources: sequential, branch, jump/call, return, and exception vector.
- Masks every PC to a parametrised address window.
- Adds stall, a small return-address stack (RAS), misalignment trapping and EPC capture.
- Sits between the control/branch unit and instruction memory, replacing the plain PC register.

Parameters:
N, 32, datapath width of all PC/target/EPC values
ADDR_BITS, 20, low PC bits retained; bits [N-1:ADDR_BITS] are always forced to 0
RESET_VECTOR, 0, PC value loaded on reset (masked)
EXC_VECTOR, 32'h0000_0180, PC value loaded on exception/trap (masked)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clk
i_Stall_b  in  1  hold PC and RAS unchanged this cycle
i_Branch_b  in  1  take branch to i_BranchTarget_dw
i_BranchTarget_dw  in  N  branch target
i_Jump_b  in  1  take jump to i_JumpTarget_dw
i_Call_b  in  1  qualifies i_Jump_b: also push PC+4 onto RAS
i_JumpTarget_dw  in  N  jump/call target
i_Return_b  in  1  pop RAS and redirect to popped address
i_Exception_b  in  1  external exception request
o_PCValue_dw  out  N  current PC (registered)
o_PCPlus4_dw  out  N  masked PC+4 (combinational from o_PCValue_dw)
o_EPC_dw  out  N  PC captured at the last trap
o_Trap_b  out  1  one-cycle pulse: a trap redirect occurred this edge
o_TrapCause_dw  out  2  00 external, 01 misaligned target, 10 RAS underflow; held until next trap
o_RasEmpty_b  out  1  RAS count == 0
o_RasFull_b  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset, synchronous and active-high:
  - o_PCValue_dw = RESET_VECTOR masked.
  - o_EPC_dw = 0, o_TrapCause_dw = 0, o_Trap_b = 0.
  - RAS pointer and count = 0, so o_RasEmpty_b = 1 and o_RasFull_b = 0.
  - Reset overrides every other input, including mid-stall and mid-trap.
- Mask function M(x) = {0, x[ADDR_BITS-1:0]}. It is applied to every value loaded into the PC.
- PC+4 wraps to 0 past 2^ADDR_BITS-4.
- Next-PC priority, highest first; one source per edge:
  1. i_Exception_b → trap, cause 00. Overrides stall.
  2. i_Stall_b → PC, RAS, EPC and cause all hold; o_Trap_b = 0.
  3. i_Return_b:
     - RAS empty → trap, cause 10.
     - Otherwise PC = popped entry and count decrements.
  4. i_Jump_b → PC = M(target).
     - If i_Call_b is also asserted, push M(PC+4) in the same edge.
     - i_Call_b without i_Jump_b is ignored.
  5. i_Branch_b → PC = M(target).
  6. Otherwise PC = M(PC+4).
- Misalignment: a selected branch/jump target with [1:0] != 0 is not taken.
  - It traps with cause 01.
  - A call that traps does not push.
- Trap action:
  - PC = M(EXC_VECTOR).
  - o_EPC_dw = current o_PCValue_dw.
  - o_TrapCause_dw updated.
  - o_Trap_b = 1 for exactly that cycle.
  - RAS unchanged.
- Return and call together: the return wins; the call is ignored and there is no push.
- RAS overflow: a push when full overwrites the oldest entry (circular). Count saturates at RAS_DEPTH and o_RasFull_b stays 1.
- Latency: every redirect is visible on o_PCValue_dw one clock after the request. There are no bubbles.
- Timing rules:
  - o_RasEmpty_b and o_RasFull_b reflect the post-edge state.
  - All outputs except o_PCPlus4_dw are registered.

Test Plan:
- Reset then 3 free-running cycles → PC 0x0, 0x4, 0x8, 0xC. Assert reset while i_Jump_b=1 → PC=0x0 next edge.
- Sequential wrap: ADDR_BITS=20, PC reaches 0x000F_FFFC → next PC 0x0. A branch to 0xFFF0_1234 → PC 0x0000_1234 (upper bits masked).
- Stall vs exception: i_Stall_b=1 for 2 cycles with i_Branch_b=1 → PC held at 0x100. Then stall + i_Exception_b → PC=0x180, EPC=0x100, o_Trap_b pulse of 1 cycle, cause 00.
- Call/return: call at PC 0x40 to 0x200 → PC 0x200, RAS holds 0x44. Return → PC 0x44, o_RasEmpty_b=1. A further return → trap, cause 10, EPC=0x48.
- RAS overflow: 5 calls with RAS_DEPTH=4 → o_RasFull_b=1. Then 4 returns pop the newest four addresses in LIFO order; the 5th return traps with cause 10.
- Misaligned target: jump+call to 0x202 at PC 0x60 → PC 0x180, cause 01, EPC=0x60, no push (o_RasEmpty_b stays 1).

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program counter with prioritised next-PC selection, address-window masking,
// a circular return-address stack, misalignment trapping and EPC capture.
module pc_sequencer #(
  parameter int unsigned  N            = 32,
  parameter int unsigned  ADDR_BITS    = 20,
  parameter logic [N-1:0] RESET_VECTOR = '0,
  parameter logic [N-1:0] EXC_VECTOR   = N'(32'h0000_0180),
  parameter int unsigned  RAS_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_Stall_b,
  input  logic         i_Branch_b,
  input  logic [N-1:0] i_BranchTarget_dw,
  input  logic         i_Jump_b,
  input  logic         i_Call_b,
  input  logic [N-1:0] i_JumpTarget_dw,
  input  logic         i_Return_b,
  input  logic         i_Exception_b,
  output logic [N-1:0] o_PCValue_dw,
  output logic [N-1:0] o_PCPlus4_dw,
  output logic [N-1:0] o_EPC_dw,
  output logic         o_Trap_b,
  output logic [1:0]   o_TrapCause_dw,
  output logic         o_RasEmpty_b,
  output logic         o_RasFull_b
);

  localparam int unsigned  PTR_W     = $clog2(RAS_DEPTH);
  localparam int unsigned  CNT_W     = $clog2(RAS_DEPTH + 1);
  // ADDR_BITS must be smaller than N
  localparam logic [N-1:0] ADDR_MASK = {{(N-ADDR_BITS){1'b0}}, {ADDR_BITS{1'b1}}};
  localparam logic [1:0]   CAUSE_EXT = 2'b00;
  localparam logic [1:0]   CAUSE_MIS = 2'b01;
  localparam logic [1:0]   CAUSE_UNF = 2'b10;

  function automatic logic [N-1:0] mask_addr(input logic [N-1:0] x);
    return x & ADDR_MASK;
  endfunction

  logic [N-1:0]     pc_q, pc_d;
  logic [N-1:0]     epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic             trap_q, trap_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [N-1:0]     ras_q [RAS_DEPTH];
  logic [N-1:0]     ras_d [RAS_DEPTH];

  logic [N-1:0]     pc_plus4;
  logic             take_trap;
  logic [1:0]       trap_cause;

  assign pc_plus4 = mask_addr(pc_q + N'(4));

  // Next-PC selection; a trap overrides whatever the priority chain picked.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    trap_d     = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ras_d      = ras_q;
    take_trap  = 1'b0;
    trap_cause = CAUSE_EXT;

    if (i_Exception_b) begin
      take_trap = 1'b1;
    end else if (i_Stall_b) begin
      pc_d = pc_q;
    end else if (i_Return_b) begin
      if (cnt_q == CNT_W'(0)) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_UNF;
      end else begin
        ptr_d = ptr_q - PTR_W'(1);
        pc_d  = ras_q[ptr_q - PTR_W'(1)];
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (i_Jump_b) begin
      if (i_JumpTarget_dw[1:0] != 2'b00) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_MIS;
      end else begin
        pc_d = mask_addr(i_JumpTarget_dw);
        // Full stack: the write lands on the oldest slot and the count saturates
        if (i_Call_b) begin
          ras_d[ptr_q] = pc_plus4;
          ptr_d        = ptr_q + PTR_W'(1);
          if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (i_Branch_b) begin
      if (i_BranchTarget_dw[1:0] != 2'b00) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_MIS;
      end else begin
        pc_d = mask_addr(i_BranchTarget_dw);
      end
    end else begin
      pc_d = pc_plus4;
    end

    if (take_trap) begin
      pc_d    = mask_addr(EXC_VECTOR);
      epc_d   = pc_q;
      cause_d = trap_cause;
      trap_d  = 1'b1;
    end

    empty_d = (cnt_d == CNT_W'(0));
    full_d  = (cnt_d == CNT_W'(RAS_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= mask_addr(RESET_VECTOR);
      epc_q   <= '0;
      cause_q <= '0;
      trap_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      trap_q  <= trap_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ras_q   <= ras_d;
    end
  end

  assign o_PCValue_dw   = pc_q;
  assign o_PCPlus4_dw   = pc_plus4;
  assign o_EPC_dw       = epc_q;
  assign o_Trap_b       = trap_q;
  assign o_TrapCause_dw = cause_q;
  assign o_RasEmpty_b   = empty_q;
  assign o_RasFull_b    = full_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked
// against a queue-based behavioural model of the fetch PC.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, br, jmp, call, ret, exc;
  logic [31:0] bt, jt;
  logic [31:0] pc, pc4, epc;
  logic        trap, ras_empty, ras_full;
  logic [1:0]  cause;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Behavioural model state
  int unsigned m_pc, m_epc, m_cause;
  bit          m_trap;
  int unsigned m_ras[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .i_Stall_b         (stall),
    .i_Branch_b        (br),
    .i_BranchTarget_dw (bt),
    .i_Jump_b          (jmp),
    .i_Call_b          (call),
    .i_JumpTarget_dw   (jt),
    .i_Return_b        (ret),
    .i_Exception_b     (exc),
    .o_PCValue_dw      (pc),
    .o_PCPlus4_dw      (pc4),
    .o_EPC_dw          (epc),
    .o_Trap_b          (trap),
    .o_TrapCause_dw    (cause),
    .o_RasEmpty_b      (ras_empty),
    .o_RasFull_b       (ras_full)
  );

  function automatic int unsigned msk(input int unsigned x);
    return x % (1 << 20);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_trap(input int unsigned c);
    m_epc   = m_pc;
    m_pc    = msk(32'h180);
    m_cause = c;
    m_trap  = 1;
  endtask

  task automatic model_update();
    m_trap = 0;
    if (reset) begin
      m_pc = 0; m_epc = 0; m_cause = 0;
      m_ras.delete();
    end else if (exc) model_trap(0);
    else if (stall) m_trap = 0;
    else if (ret) begin
      if (m_ras.size() == 0) model_trap(2);
      else m_pc = m_ras.pop_back();
    end else if (jmp) begin
      if (jt % 4 != 0) model_trap(1);
      else begin
        if (call) begin
          m_ras.push_back(msk(m_pc + 4));
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        m_pc = msk(jt);
      end
    end else if (br) begin
      if (bt % 4 != 0) model_trap(1);
      else m_pc = msk(bt);
    end else m_pc = msk(m_pc + 4);
  endtask

  task automatic check_all();
    chk("pc",     pc,  m_pc);
    chk("pc4",    pc4, msk(m_pc + 4));
    chk("epc",    epc, m_epc);
    chk("trap",   32'(trap), 32'(m_trap));
    chk("cause",  32'(cause), m_cause);
    chk("empty",  32'(ras_empty), 32'(m_ras.size() == 0));
    chk("full",   32'(ras_full),  32'(m_ras.size() == 4));
  endtask

  task automatic step(input logic r, s, b, input logic [31:0] btv,
                      input logic j, c, input logic [31:0] jtv, input logic rt, e);
    reset = r; stall = s; br = b; bt = btv; jmp = j; call = c; jt = jtv; ret = rt; exc = e;
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; stall = 0; br = 0; jmp = 0; call = 0; ret = 0; exc = 0; bt = 0; jt = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("plan_reset_pc", pc, 32'h0);
    idle(); idle(); idle();
    chk("plan_free_run", pc, 32'hC);
    step(1, 0, 0, 0, 1, 0, 32'h400, 0, 0);
    chk("plan_reset_over_jump", pc, 32'h0);

    // Sequential wrap and upper-bit masking
    step(0, 0, 1, 32'h000F_FFF8, 0, 0, 0, 0, 0);
    idle();
    chk("plan_top", pc, 32'h000F_FFFC);
    idle();
    chk("plan_wrap", pc, 32'h0);
    step(0, 0, 1, 32'hFFF0_1234, 0, 0, 0, 0, 0);
    chk("plan_mask", pc, 32'h0000_1234);

    // Stall holds, exception overrides stall
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h300, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h300, 0, 0, 0, 0, 0);
    chk("plan_stall_hold", pc, 32'h100);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("plan_exc_epc", epc, 32'h100);
    idle();
    chk("plan_trap_pulse", 32'(trap), 32'h0);

    // Call / return / underflow
    step(0, 0, 1, 32'h40, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h200, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("plan_ret_pc", pc, 32'h44);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("plan_unf_cause", 32'(cause), 32'h2);
    chk("plan_unf_epc", epc, 32'h48);

    // Overflow: five calls then five returns
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1, 32'h300 + 32'(i * 16), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("plan_ovf_cause", 32'(cause), 32'h2);

    // Misaligned call traps without pushing
    step(0, 0, 1, 32'h60, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h202, 0, 0);
    chk("plan_mis_epc", epc, 32'h60);
    chk("plan_mis_cause", 32'(cause), 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rb, rj;
      rb = $urandom; rj = $urandom;
      if ($urandom_range(7) != 0) rb[1:0] = 2'b00;
      if ($urandom_range(7) != 0) rj[1:0] = 2'b00;
      step(($urandom_range(99) == 0), ($urandom_range(5) == 0), ($urandom_range(3) == 0), rb,
           ($urandom_range(3) == 0), ($urandom_range(1) == 0), rj,
           ($urandom_range(5) == 0), ($urandom_range(19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
